int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//   Memory-mapped interrupt controller between the interrupt sources (Timer1 IRQ, Timer2 IRQ, external interrupt) and the CPU.
//   Latches and masks requests, selects one by fixed priority and raises a single request to the CPU.
//   Waits for the CPU acknowledge, then holds that source in service until software writes EOI through the bridge.
// PARAMETERS
//   NSRC  6  number of interrupt sources, 1..8; source 0 has the highest priority
// PORTS
//   clk      in   1     system clock
//   reset    in   1     asynchronous, active-high reset
//   irq_src  in   NSRC  raw interrupt lines; bit0=Timer1, bit1=Timer2, bit2=external, rest spare
//   sel      in   1     bridge chip-select for this block
//   WE       in   1     register write enable; only acts when sel=1
//   Addr     in   3     word offset inside the block: 0 PEND, 1 MASK, 2 EDGE, 3 VEC, 4 EOI
//   Din      in   32    write data
//   Dout     out  32    read data, combinational from Addr
//   int_req  out  1     request to the CPU
//   HWInt    out  NSRC  one-hot of the selected source while int_req=1, else 0
//   int_ack  in   1     one-cycle pulse from the CPU when it takes the interrupt
// BEHAVIOUR
// - Reset values: PEND=0, MASK=0 (all disabled), EDGE=0, VEC=0, prev-sample register=0, state=IDLE, int_req=0, HWInt=0.
// - Sampling: irq_src is registered into s every cycle.
//   - Edge source (EDGE[i]=1): PEND[i] is set when s[i] & ~prev[i].
//   - Level source (EDGE[i]=0): PEND[i] <= s[i] every cycle.
//   - Latency: irq_src rises at edge n, s captures it at n+1, PEND sets at n+2, int_req asserts at n+3.
// - Register writes (sel & WE):
//   - PEND: write-1-to-clear, edge sources only. If a new edge arrives in the same cycle, set wins.
//   - MASK and EDGE: full write of bits [NSRC-1:0].
//   - VEC: read-only; writes are ignored.
//   - EOI: any write; only acts in SERVICE.
// - Reads: Dout = {zeros, reg[NSRC-1:0]}. VEC = {valid, 28'b0, id[2:0]}. EOI and unmapped offsets read 0.
// - Candidate vector: cand = PEND & MASK. Selected id = lowest set index of cand.
// - FSM:
//   - IDLE: if cand!=0, latch id and go to REQ.
//   - REQ: int_req=1 and HWInt=1<<id.
//     - int_ack=1: go to SERVICE; VEC={1,id}; PEND[id] cleared if the source is edge type.
//     - cand[id]=0 (masked or level drop) with no ack: withdraw and go to IDLE.
//     - The latched id is held while in REQ; a higher-priority arrival does not preempt it.
//   - SERVICE: int_req=0, no nesting; sources keep latching into PEND. An EOI write sets VEC=0 and goes to IDLE next cycle.
// - An ack in IDLE or SERVICE is ignored. An EOI outside SERVICE is ignored. Simultaneous ack and withdraw in REQ: ack wins.
// - An async reset mid-operation returns everything to the reset values immediately; any pending request is lost.
// TESTING
//   1. MASK=0x3, EDGE=0x3; 1-cycle pulse on irq_src[1] -> int_req=1 and HWInt=6'b000010 three cycles later; ack -> VEC=0x80000001, PEND=0.
//   2. Edges on src0 and src1 in the same cycle, MASK=0x3 -> id 0 served first; after EOI, REQ for id 1 with HWInt=6'b000010.
//   3. Level src2 high, MASK=0x4 -> REQ; clear MASK before ack -> int_req=0 next cycle, state IDLE.
//   4. W1C write to PEND[0] in the same cycle as a new edge on src0 -> PEND[0]=1.
//   5. Write EOI in IDLE and pulse int_ack in SERVICE -> no state change; read VEC returns its current value.
//   6. Assert reset while in SERVICE -> int_req=0, VEC=0, MASK=0 immediately; no request after reset is released.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Bus bundle between the CPU/bridge side and the interrupt controller.
interface int_ctrl_if #(parameter int unsigned NSRC = 6);
   logic [NSRC-1:0] irq_src;
   logic            sel;
   logic            WE;
   logic [2:0]      Addr;
   logic [31:0]     Din;
   logic [31:0]     Dout;
   logic            int_req;
   logic [NSRC-1:0] HWInt;
   logic            int_ack;

   modport master (
      output irq_src, sel, WE, Addr, Din, int_ack,
      input  Dout, int_req, HWInt
   );

   modport slave (
      input  irq_src, sel, WE, Addr, Din, int_ack,
      output Dout, int_req, HWInt
   );
endinterface

// File: rtl/int_ctrl.sv
// Memory-mapped fixed-priority interrupt controller: latch, mask, request,
// acknowledge, then hold the source in service until software writes EOI.
module int_ctrl #(
   parameter int unsigned NSRC = 6
) (
   input logic      clk,
   input logic      reset,
   int_ctrl_if.slave bus
);
   localparam int unsigned IDW = 3;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state_q, state_nx;
   logic [NSRC-1:0] s_q, prev_q, pend_q, mask_q, edge_q;
   logic [NSRC-1:0] cand, clr, pend_nx, hwint_q;
   logic [IDW-1:0]  id_q, id_nx, sel_id, vec_id_q;
   logic            vec_valid_q, int_req_q, found;
   logic            wr, wr_pend, wr_mask, wr_edge, wr_eoi;
   logic            take_ack, take_eoi;
   logic [31:0]     unused_din;

   assign wr      = bus.sel & bus.WE;
   assign wr_pend = wr && (bus.Addr == 3'd0);
   assign wr_mask = wr && (bus.Addr == 3'd1);
   assign wr_edge = wr && (bus.Addr == 3'd2);
   assign wr_eoi  = wr && (bus.Addr == 3'd4);
   assign unused_din = bus.Din;

   assign cand = pend_q & mask_q;

   // Lowest set index of the candidate vector wins.
   always_comb begin
      sel_id = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (cand[i] && !found) begin
            sel_id = IDW'(i);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state_q;
      id_nx    = id_q;
      take_ack = 1'b0;
      take_eoi = 1'b0;
      case (state_q)
         IDLE: begin
            if (|cand) begin
               state_nx = REQ;
               id_nx    = sel_id;
            end
         end
         REQ: begin
            if (bus.int_ack) begin
               take_ack = 1'b1;
               state_nx = SERVICE;
            end else if (!cand[id_q]) begin
               state_nx = IDLE;
            end
         end
         SERVICE: begin
            if (wr_eoi) begin
               take_eoi = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Edge sources: clear (W1C or ack) loses against a same-cycle new edge.
   always_comb begin
      clr = '0;
      if (wr_pend) clr = bus.Din[NSRC-1:0];
      if (take_ack) clr[id_q] = 1'b1;
      pend_nx = (edge_q & ((pend_q & ~clr) | (s_q & ~prev_q))) | (~edge_q & s_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         id_q        <= '0;
         s_q         <= '0;
         prev_q      <= '0;
         pend_q      <= '0;
         mask_q      <= '0;
         edge_q      <= '0;
         vec_valid_q <= 1'b0;
         vec_id_q    <= '0;
         int_req_q   <= 1'b0;
         hwint_q     <= '0;
      end else begin
         state_q <= state_nx;
         id_q    <= id_nx;
         s_q     <= bus.irq_src;
         prev_q  <= s_q;
         pend_q  <= pend_nx;
         if (wr_mask) mask_q <= bus.Din[NSRC-1:0];
         if (wr_edge) edge_q <= bus.Din[NSRC-1:0];
         if (take_ack) begin
            vec_valid_q <= 1'b1;
            vec_id_q    <= id_q;
         end else if (take_eoi) begin
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
         end
         // Outputs registered from next state so REQ is visible the cycle it is entered.
         int_req_q <= (state_nx == REQ);
         hwint_q   <= (state_nx == REQ) ? (NSRC'(1) << id_nx) : '0;
      end
   end

   assign bus.int_req = int_req_q;
   assign bus.HWInt   = hwint_q;

   always_comb begin
      bus.Dout = '0;
      case (bus.Addr)
         3'd0:    bus.Dout = 32'(pend_q);
         3'd1:    bus.Dout = 32'(mask_q);
         3'd2:    bus.Dout = 32'(edge_q);
         3'd3:    bus.Dout = {vec_valid_q, 28'b0, vec_id_q};
         default: bus.Dout = '0;
      endcase
   end
endmodule
